// File: rtl/if_id_decode_stage.sv
// IF/ID stage: 2-entry skid FIFO of {instr, pc}. The head entry is split into
// register addresses and an immediate/extension-mode pair for ext_module.
module if_id_decode_stage #(
  parameter int          PC_W       = 32,
  parameter int          REG_AW     = 4,
  parameter logic [5:0]  ILLEGAL_OP = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [5:0]        opcode,
  output logic [REG_AW-1:0] rd,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [25:0]       imm,
  output logic [1:0]        imm_ctrl,
  output logic              illegal
);

  logic [31:0]     instr_q [2];
  logic [PC_W-1:0] pc_q    [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic [31:0]     head_instr;

  // Handshake is driven only by registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= in_instr;
        pc_q[wr_ptr]    <= in_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // An empty buffer presents a zero instruction so stale entries never leak out.
  assign head_instr = out_valid ? instr_q[rd_ptr] : 32'd0;
  assign out_pc     = out_valid ? pc_q[rd_ptr] : '0;

  assign opcode = head_instr[31:26];
  assign rd     = head_instr[25 -: REG_AW];
  assign rs1    = head_instr[21 -: REG_AW];
  assign rs2    = head_instr[17 -: REG_AW];

  always_comb begin
    imm      = 26'd0;
    imm_ctrl = 2'b00;
    case (head_instr[31:30])
      2'b00: begin
        imm      = 26'd0;
        imm_ctrl = 2'b00;
      end
      2'b01: begin
        imm      = {13'd0, head_instr[12:0]};
        imm_ctrl = 2'b00;
      end
      2'b10: begin
        imm      = {13'd0, head_instr[12:0]};
        imm_ctrl = 2'b01;
      end
      default: begin
        imm      = head_instr[25:0];
        imm_ctrl = 2'b10;
      end
    endcase
  end

  assign illegal = out_valid & (head_instr[31:26] == ILLEGAL_OP);

endmodule

// File: tb/tb_if_id_decode_stage.sv
// Scoreboard bench for if_id_decode_stage: driver queues hand-decoded expectations,
// a negedge monitor pops and compares each retired head entry.
module tb_if_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  opcode;
  logic [3:0]  rd, rs1, rs2;
  logic [25:0] imm;
  logic [1:0]  imm_ctrl;
  logic        illegal;

  always #5 clk = ~clk;

  if_id_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .imm_ctrl(imm_ctrl), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [25:0] imm;
    logic [1:0]  ctrl;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs [11];
  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every retired head must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output_pc", out_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("pc",       out_pc,   e.pc);
        chk("opcode",   32'(opcode),   32'(e.v.op));
        chk("rd",       32'(rd),       32'(e.v.rd));
        chk("rs1",      32'(rs1),      32'(e.v.rs1));
        chk("rs2",      32'(rs2),      32'(e.v.rs2));
        chk("imm",      32'(imm),      32'(e.v.imm));
        chk("imm_ctrl", 32'(imm_ctrl), 32'(e.v.ctrl));
        chk("illegal",  32'(illegal),  32'(e.v.ill));
      end
    end
  end

  // Presents one instruction from posedge+1 until accepted; returns wait cycles.
  task automatic send(input int idx, input logic [31:0] pc, output int stalls);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_pc    = pc;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (in_ready) begin
        exp_t e;
        e.v  = vecs[idx];
        e.pc = pc;
        sb_q.push_back(e);
        ok = 1'b1;
      end else begin
        n++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    stalls = n;
  endtask

  initial begin
    int st;
    //            instr          op     rd    rs1   rs2   imm           ctrl   ill
    vecs[0]  = '{32'h4000_0003, 6'h10, 4'h0, 4'h0, 4'h0, 26'h0000003,  2'b00, 1'b0};
    vecs[1]  = '{32'h8000_1000, 6'h20, 4'h0, 4'h0, 4'h0, 26'h0001000,  2'b01, 1'b0};
    vecs[2]  = '{32'hC3FF_FFFF, 6'h30, 4'hF, 4'hF, 4'hF, 26'h3FFFFFF,  2'b10, 1'b0};
    vecs[3]  = '{32'hFC00_0000, 6'h3F, 4'h0, 4'h0, 4'h0, 26'h0000000,  2'b10, 1'b1};
    vecs[4]  = '{32'h14E7_1234, 6'h05, 4'h3, 4'h9, 4'hC, 26'h0000000,  2'b00, 1'b0};
    vecs[5]  = '{32'h5FFF_FFFF, 6'h17, 4'hF, 4'hF, 4'hF, 26'h0001FFF,  2'b00, 1'b0};
    vecs[6]  = '{32'h8800_0ABC, 6'h22, 4'h0, 4'h0, 4'h0, 26'h0000ABC,  2'b01, 1'b0};
    vecs[7]  = vecs[0];
    vecs[8]  = vecs[1];
    vecs[9]  = vecs[2];
    vecs[10] = '{32'h4000_0077, 6'h10, 4'h0, 4'h0, 4'h0, 26'h0000077,  2'b00, 1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_imm",       32'(imm),       32'd0);
    chk("rst_imm_ctrl",  32'(imm_ctrl),  32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // first push: visible one cycle after acceptance
    out_ready = 1'b1;
    send(0, 32'h100, st);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("latency_imm", 32'(imm), 32'h3);

    // streaming: count sits at 1 with push+pop every cycle, never stalls
    send(1, 32'h104, st); chk("stream_stall1", st, 0);
    send(2, 32'h108, st); chk("stream_stall2", st, 0);
    send(4, 32'h10C, st); chk("stream_stall3", st, 0);
    send(5, 32'h110, st); chk("stream_stall4", st, 0);
    send(6, 32'h114, st); chk("stream_stall5", st, 0);
    repeat (3) @(posedge clk);
    #1 chk("drained_out_valid", 32'(out_valid), 32'd0);

    // back-pressure: fill both entries, third waits, then in-order drain
    out_ready = 1'b0;
    send(7, 32'h200, st);
    send(8, 32'h204, st);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      begin
        send(9, 32'h208, st);
        chk("third_held", 32'(st != 0), 32'd1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("held_in_ready", 32'(in_ready), 32'd0);
        chk("held_head_pc", out_pc, 32'h200);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1 chk("fill_drained", 32'(out_valid), 32'd0);

    // count==1 then simultaneous push+pop: new entry becomes head
    out_ready = 1'b0;
    send(4, 32'h300, st);
    out_ready = 1'b1;
    send(5, 32'h304, st);
    chk("pushpop_out_valid", 32'(out_valid), 32'd1);
    chk("pushpop_head_pc", out_pc, 32'h304);
    repeat (2) @(posedge clk);
    #1;

    // flush while full with a push pending
    out_ready = 1'b0;
    send(0, 32'h400, st);
    send(1, 32'h404, st);
    in_valid = 1'b1; in_instr = vecs[10].instr; in_pc = 32'hDEAD; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    chk("flush_imm",       32'(imm),       32'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // illegal opcode
    send(3, 32'h500, st);
    repeat (2) @(posedge clk);
    #1;

    // async reset between edges
    out_ready = 1'b0;
    send(2, 32'h600, st);
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready",  32'(in_ready),  32'd1);
    chk("async_out_pc",    out_pc,         32'd0);
    chk("async_imm",       32'(imm),       32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(6, 32'h700, st);
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
